// File: rtl/alarm_ring_ctrl.sv
// Alarm sounder sequencer: rings on alarm match, beeps 1 s on / 1 s off,
// handles snooze intervals, stop and ring timeout.
module alarm_ring_ctrl #(
   parameter int RING_SECS   = 60,
   parameter int SNOOZE_SECS = 300,
   parameter int MAX_SNOOZE  = 3,
   parameter int CNT_W       = 9
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        one_second,
   input  logic        alarm_on,
   input  logic [15:0] current_time,
   input  logic [15:0] alarm_time,
   input  logic        stop_button,
   input  logic        snooze_button,
   output logic        sound,
   output logic        ringing,
   output logic        snoozing,
   output logic [1:0]  snooze_count
);

   // state      | meaning
   // IDLE       | armed, waiting for alarm match
   // RINGING    | buzzer active, beep_phase gates sound
   // SNOOZE     | silent interval, re-rings after SNOOZE_SECS
   // WAIT_CLEAR | silenced, waiting for the matching minute to pass
   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      RINGING    = 2'd1,
      SNOOZE     = 2'd2,
      WAIT_CLEAR = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] RING_TC   = CNT_W'(RING_SECS - 1);
   localparam logic [CNT_W-1:0] SNOOZE_TC = CNT_W'(SNOOZE_SECS - 1);
   localparam logic [1:0]       SNZ_MAX   = 2'(MAX_SNOOZE);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] sec_cnt, sec_cnt_nxt;
   logic             beep_phase, beep_phase_nxt;
   logic [1:0]       snooze_cnt_nxt;
   logic             one_second_d;
   logic             tick;
   logic             match;
   logic             quit;

   assign tick  = one_second & ~one_second_d;
   assign match = alarm_on & (current_time == alarm_time);
   assign quit  = stop_button | ~alarm_on;

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         sec_cnt      <= '0;
         beep_phase   <= 1'b0;
         snooze_count <= 2'd0;
         one_second_d <= 1'b0;
      end else begin
         state        <= state_nxt;
         sec_cnt      <= sec_cnt_nxt;
         beep_phase   <= beep_phase_nxt;
         snooze_count <= snooze_cnt_nxt;
         one_second_d <= one_second;
      end
   end

   always_comb begin
      state_nxt      = state;
      sec_cnt_nxt    = sec_cnt;
      beep_phase_nxt = beep_phase;
      snooze_cnt_nxt = snooze_count;
      unique case (state)
         IDLE: begin
            if (match) begin
               state_nxt      = RINGING;
               sec_cnt_nxt    = '0;
               beep_phase_nxt = 1'b1;
            end
         end
         RINGING: begin
            // stop beats snooze, and both beat a coincident tick
            if (quit) begin
               state_nxt   = WAIT_CLEAR;
               sec_cnt_nxt = '0;
            end else if (snooze_button && (snooze_count < SNZ_MAX)) begin
               state_nxt      = SNOOZE;
               snooze_cnt_nxt = snooze_count + 2'd1;
               sec_cnt_nxt    = '0;
            end else if (tick) begin
               if (sec_cnt == RING_TC) begin
                  state_nxt   = WAIT_CLEAR;
                  sec_cnt_nxt = '0;
               end else begin
                  sec_cnt_nxt    = sec_cnt + 1'b1;
                  beep_phase_nxt = ~beep_phase;
               end
            end
         end
         SNOOZE: begin
            if (quit) begin
               state_nxt   = WAIT_CLEAR;
               sec_cnt_nxt = '0;
            end else if (tick) begin
               if (sec_cnt == SNOOZE_TC) begin
                  state_nxt      = RINGING;
                  sec_cnt_nxt    = '0;
                  beep_phase_nxt = 1'b1;
               end else begin
                  sec_cnt_nxt = sec_cnt + 1'b1;
               end
            end
         end
         WAIT_CLEAR: begin
            if (!match) begin
               state_nxt      = IDLE;
               snooze_cnt_nxt = 2'd0;
               sec_cnt_nxt    = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign ringing  = (state == RINGING);
   assign snoozing = (state == SNOOZE);
   assign sound    = ringing & beep_phase;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed bench for alarm_ring_ctrl: table of single-cycle vectors plus
// hand-written multi-cycle corner cases.
module tb_alarm_ring_ctrl;

   localparam int RING_SECS   = 4;
   localparam int SNOOZE_SECS = 3;
   localparam int MAX_SNOOZE  = 2;
   localparam int CNT_W       = 9;

   logic        clock = 1'b0;
   logic        reset;
   logic        one_second;
   logic        alarm_on;
   logic [15:0] current_time;
   logic [15:0] alarm_time;
   logic        stop_button;
   logic        snooze_button;
   logic        sound;
   logic        ringing;
   logic        snoozing;
   logic [1:0]  snooze_count;

   int n_checks = 0;
   int n_fail   = 0;

   // expected outputs packed as {ringing, snoozing, sound, snooze_count}
   typedef struct {
      logic        stop;
      logic        snz;
      logic        os;
      logic        on;
      logic [15:0] cur;
      logic [4:0]  exp;
   } vec_t;

   vec_t vecs[$];

   alarm_ring_ctrl #(
      .RING_SECS  (RING_SECS),
      .SNOOZE_SECS(SNOOZE_SECS),
      .MAX_SNOOZE (MAX_SNOOZE),
      .CNT_W      (CNT_W)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .one_second   (one_second),
      .alarm_on     (alarm_on),
      .current_time (current_time),
      .alarm_time   (alarm_time),
      .stop_button  (stop_button),
      .snooze_button(snooze_button),
      .sound        (sound),
      .ringing      (ringing),
      .snoozing     (snoozing),
      .snooze_count (snooze_count)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [4:0] exp);
      logic [4:0] act;
      act = {ringing, snoozing, sound, snooze_count};
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got {ring,snz,snd,cnt}=%b expected %b", name, act, exp);
      end
   endtask

   task automatic pulse();
      one_second = 1'b1;
      step();
      one_second = 1'b0;
      step();
   endtask

   task automatic add(input logic stop, input logic snz, input logic os,
                      input logic [15:0] cur, input logic [4:0] exp);
      vec_t v;
      v.stop = stop; v.snz = snz; v.os = os; v.on = 1'b1; v.cur = cur; v.exp = exp;
      vecs.push_back(v);
   endtask

   initial begin
      // basic ring, beep toggling and timeout
      add(0,0,0,16'h1258,5'b00000);
      add(0,0,0,16'h1259,5'b10100);
      add(0,0,1,16'h1259,5'b10000);
      add(0,0,0,16'h1259,5'b10000);
      add(0,0,1,16'h1259,5'b10100);
      add(0,0,0,16'h1259,5'b10100);
      add(0,0,1,16'h1259,5'b10000);
      add(0,0,0,16'h1259,5'b10000);
      add(0,0,1,16'h1259,5'b00000);
      add(0,0,0,16'h1259,5'b00000);
      add(0,0,0,16'h1300,5'b00000);
      // stop
      add(0,0,0,16'h1259,5'b10100);
      add(1,0,0,16'h1259,5'b00000);
      add(0,0,0,16'h1300,5'b00000);
      // snooze cycle up to the limit, then timeout
      add(0,0,0,16'h1259,5'b10100);
      add(0,1,0,16'h1259,5'b01001);
      add(0,0,1,16'h1259,5'b01001);
      add(0,0,0,16'h1259,5'b01001);
      add(0,0,1,16'h1259,5'b01001);
      add(0,0,0,16'h1259,5'b01001);
      add(0,0,1,16'h1259,5'b10101);
      add(0,0,0,16'h1259,5'b10101);
      add(0,1,0,16'h1259,5'b01010);
      add(0,0,1,16'h1259,5'b01010);
      add(0,0,0,16'h1259,5'b01010);
      add(0,0,1,16'h1259,5'b01010);
      add(0,0,0,16'h1259,5'b01010);
      add(0,0,1,16'h1259,5'b10110);
      add(0,1,0,16'h1259,5'b10110);
      add(0,1,1,16'h1259,5'b10010);
      add(0,0,0,16'h1259,5'b10010);
      add(0,0,1,16'h1259,5'b10110);
      add(0,0,0,16'h1259,5'b10110);
      add(0,0,1,16'h1259,5'b10010);
      add(0,0,0,16'h1259,5'b10010);
      add(0,0,1,16'h1259,5'b00010);
      add(0,0,0,16'h1300,5'b00000);

      reset = 1'b1; one_second = 1'b0; alarm_on = 1'b1;
      current_time = 16'h1258; alarm_time = 16'h1259;
      stop_button = 1'b0; snooze_button = 1'b0;
      step(); step();
      chk("reset_state", 5'b00000);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         stop_button   = vecs[i].stop;
         snooze_button = vecs[i].snz;
         one_second    = vecs[i].os;
         alarm_on      = vecs[i].on;
         current_time  = vecs[i].cur;
         step();
         chk($sformatf("vec%0d", i), vecs[i].exp);
      end
      stop_button = 0; snooze_button = 0; one_second = 0;

      // held strobe counts as one second
      current_time = 16'h1259; step();
      chk("held_start", 5'b10100);
      one_second = 1'b1;
      for (int i = 0; i < 10; i++) step();
      chk("held_one_sec", 5'b10000);
      one_second = 1'b0; step();
      pulse(); chk("held_edge2", 5'b10100);
      pulse(); chk("held_edge3", 5'b10000);
      pulse(); chk("held_edge4_timeout", 5'b00000);
      current_time = 16'h1300; step();

      // stop and snooze together (with a tick) -> stop wins
      current_time = 16'h1259; step();
      stop_button = 1; snooze_button = 1; one_second = 1; step();
      chk("stop_and_snooze", 5'b00000);
      stop_button = 0; snooze_button = 0; one_second = 0;
      current_time = 16'h1300; step();

      // stop in SNOOZE keeps count until match drops
      current_time = 16'h1259; step();
      snooze_button = 1; step(); snooze_button = 0;
      chk("snooze_before_stop", 5'b01001);
      stop_button = 1; step(); stop_button = 0;
      chk("stop_in_snooze", 5'b00001);
      step();
      chk("wait_clear_holds", 5'b00001);
      current_time = 16'h1300; step();
      chk("count_cleared", 5'b00000);

      // snooze on the terminal tick wins over timeout
      current_time = 16'h1259; step();
      pulse(); pulse(); pulse();
      chk("before_terminal", 5'b10000);
      one_second = 1; snooze_button = 1; step();
      one_second = 0; snooze_button = 0;
      chk("snooze_at_terminal", 5'b01001);
      // alarm_on dropped in SNOOZE
      alarm_on = 0; step();
      chk("alarm_off_snooze", 5'b00001);
      step();
      chk("alarm_off_idle", 5'b00000);
      current_time = 16'h1300; alarm_on = 1; step();

      // reset mid-ring with sound on, match still true
      current_time = 16'h1259; step();
      chk("pre_reset_ring", 5'b10100);
      reset = 1; step();
      chk("reset_mid_ring", 5'b00000);
      reset = 0; step();
      chk("ring_after_reset", 5'b10100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
